sel_mux_skid: RTL and testbench
===============================

# sel_mux_skid

Registered, parametrised N-input selector for datapath results (ALU result, memory read data, PC+4 and the like), with a valid/ready handshake and a two-entry skid buffer. It supersedes fixed 3:1 combinational selection wherever a select must be pipelined across a stage boundary. It sits at stage boundaries of the multicycle/pipelined core, between the result producers and the writeback or forwarding consumer. Illegal selects are flagged and counted rather than silently zeroed.

## Interface
- WIDTH, 32, data width of every input and of the output
- N_IN, 3, number of data inputs (2..16)
- SEL_W, $clog2(N_IN), select width (localparam, derived)
- DEFAULT_VAL, 0, value driven as data for an illegal select

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream beat present
- in_ready  output  1  block can accept a beat this cycle
- sel  input  SEL_W  input index; legal range 0..N_IN-1
- data_in  input  N_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  1  out_data/out_sel_err hold a beat
- out_ready  input  1  downstream accepts the beat
- out_data  output  WIDTH  selected data
- out_sel_err  output  1  the beat on out_data came from an illegal sel
- err_count  output  16  saturating count of accepted illegal-select beats

## Operation
- Accept: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
- On accept, capture {sel >= N_IN, sel >= N_IN ? DEFAULT_VAL : data_in[sel*WIDTH +: WIDTH]}. Selection and the error flag are decided at capture. Later changes on data_in or sel have no effect on a stored beat.
- Storage: main register (drives outputs) plus skid register. State is EMPTY, ONE, or FULL:
  - EMPTY: accept -> ONE (main <= beat).
  - ONE, accept and pop -> ONE (main <= new beat).
  - ONE, accept only -> FULL (skid <= new beat).
  - ONE, pop only -> EMPTY.
  - FULL: no accept is possible. Pop -> ONE (main <= skid).
- in_ready = (state != FULL). It is decoded from the state register only and never combinationally depends on out_ready or in_valid.
- out_valid = (state != EMPTY).
- err_count increments by 1 on every accepted beat with an illegal sel. It saturates at 16'hFFFF. It is cleared only by reset.
- When N_IN is a power of two, no illegal sel exists. out_sel_err stays 0 and err_count stays 0.
- Data ordering is strictly FIFO. No beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge t is visible on out_data at t+1, with out_valid=1.
- Throughput: 1 beat/cycle while out_ready is held high.
- Backpressure: after out_ready drops, one further beat can still be accepted (into skid). in_ready then deasserts in the following cycle.
- out_data and out_sel_err hold stable while out_valid=1 and out_ready=0.
- Reset, sampled at an edge with reset=1:
  - State -> EMPTY.
  - out_valid=0, out_data=0, out_sel_err=0, err_count=0, in_ready=1.
  - in_valid is ignored at that edge.
  - Reset mid-operation discards both stored beats with no pop.
- Simultaneous accept and pop in ONE: the pop consumes the old main and the new beat replaces it in the same edge.

## Test plan
- Reset, then N_IN=3: sel=1, data_in={C=32'h3,B=32'h2,A=32'h1}, one beat, out_ready=1 -> next cycle out_valid=1, out_data=32'h2, out_sel_err=0. One cycle later out_valid=0.
- Streaming: 8 beats on consecutive cycles with sel cycling 0,1,2, out_ready=1 -> 8 outputs in order, one per cycle, in_ready constantly 1.
- Backpressure: out_ready=0 while sending beats X,Y,Z -> X and Y accepted, in_ready=0 from the third cycle, Z held upstream. Raising out_ready -> X, Y, Z delivered in order, no loss.
- Illegal select: sel=3 with N_IN=3, DEFAULT_VAL=32'hDEAD_BEEF -> out_data=32'hDEADBEEF, out_sel_err=1, err_count=1. Force err_count near the limit with 65540 illegal beats -> err_count holds 16'hFFFF.
- Reset mid-operation: reset in FULL state -> next cycle out_valid=0, out_data=0, err_count=0, in_ready=1. No stale beat emerges afterwards.
- Parameter sweep: WIDTH=8, N_IN=4 -> all four inputs selectable, out_sel_err never asserts, err_count stays 0.

Source files
------------

// File: rtl/sel_mux_skid.sv
// sel_mux_skid: registered N-input result selector with a valid/ready
// handshake, a two-entry skid buffer and illegal-select flag/counter.
module sel_mux_skid #(
   parameter int unsigned        WIDTH       = 32,
   parameter int unsigned        N_IN        = 3,
   parameter logic [WIDTH-1:0]   DEFAULT_VAL = '0,
   localparam int unsigned       SEL_W       = $clog2(N_IN)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_W-1:0]      sel,
   input  logic [N_IN*WIDTH-1:0] data_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_sel_err,
   output logic [15:0]           err_count
);

   localparam int unsigned CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;

   logic               accept_c;
   logic               pop_c;
   logic [WIDTH-1:0]   beat_data_c;
   logic               beat_err_c;

   logic [WIDTH-1:0]   main_data_q;
   logic               main_err_q;
   logic [WIDTH-1:0]   skid_data_q;
   logic               skid_err_q;
   logic [CNT_W-1:0]   err_count_q;

   assign accept_c = in_valid && in_ready;
   assign pop_c    = out_valid && out_ready;

   // Select the incoming beat; an out-of-range select yields DEFAULT_VAL and the error flag.
   always_comb begin
      beat_err_c  = (32'(sel) >= N_IN);
      beat_data_c = DEFAULT_VAL;
      for (int unsigned k = 0; k < N_IN; k++) begin
         if (32'(sel) == k) begin
            beat_data_c = data_in[k*WIDTH +: WIDTH];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: occupancy of the main/skid pair.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: begin
            if (accept_c) state_d = S_ONE;
         end
         S_ONE: begin
            if (accept_c && !pop_c)      state_d = S_FULL;
            else if (!accept_c && pop_c) state_d = S_EMPTY;
         end
         S_FULL: begin
            if (pop_c) state_d = S_ONE;
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // Handshake outputs decoded from the state register only.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_EMPTY: begin
            in_ready = 1'b1;
         end
         S_ONE: begin
            in_ready  = 1'b1;
            out_valid = 1'b1;
         end
         S_FULL: begin
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Beat storage: main drives the outputs, skid absorbs the beat taken after out_ready drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_data_q <= '0;
         main_err_q  <= 1'b0;
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept_c) begin
                  main_data_q <= beat_data_c;
                  main_err_q  <= beat_err_c;
               end
            end
            S_ONE: begin
               if (accept_c && pop_c) begin
                  main_data_q <= beat_data_c;
                  main_err_q  <= beat_err_c;
               end else if (accept_c) begin
                  skid_data_q <= beat_data_c;
                  skid_err_q  <= beat_err_c;
               end
            end
            S_FULL: begin
               if (pop_c) begin
                  main_data_q <= skid_data_q;
                  main_err_q  <= skid_err_q;
               end
            end
            default: begin
               main_data_q <= main_data_q;
            end
         endcase
      end
   end

   // Saturating count of accepted illegal-select beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_count_q <= '0;
      end else if (accept_c && beat_err_c && (err_count_q != CNT_MAX)) begin
         err_count_q <= err_count_q + CNT_W'(1);
      end
   end

   assign out_data    = main_data_q;
   assign out_sel_err = main_err_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_sel_mux_skid.sv
// tb_sel_mux_skid: randomized self-checking bench for sel_mux_skid with a
// queue-based reference model (3x32 with DEFAULT_VAL, plus a 4x8 instance).
module tb_sel_mux_skid;

   logic        clk = 1'b0;
   logic        reset;

   // instance A: WIDTH=32, N_IN=3, DEFAULT_VAL=DEADBEEF
   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_sel_err_a;
   logic [1:0]  sel_a;
   logic [95:0] data_in_a;
   logic [31:0] out_data_a;
   logic [15:0] err_count_a;

   // instance B: WIDTH=8, N_IN=4
   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_sel_err_b;
   logic [1:0]  sel_b;
   logic [31:0] data_in_b;
   logic [7:0]  out_data_b;
   logic [15:0] err_count_b;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: FIFO of {err,data} with capacity two, plus saturating counter
   logic [32:0] mq_a[$];
   logic [8:0]  mq_b[$];
   logic [15:0] exp_err_a;

   always #5 clk = ~clk;

   sel_mux_skid #(.WIDTH(32), .N_IN(3), .DEFAULT_VAL(32'hDEAD_BEEF)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .sel(sel_a), .data_in(data_in_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_data(out_data_a), .out_sel_err(out_sel_err_a), .err_count(err_count_a));

   sel_mux_skid #(.WIDTH(8), .N_IN(4)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .sel(sel_b), .data_in(data_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_data(out_data_b), .out_sel_err(out_sel_err_b), .err_count(err_count_b));

   function automatic logic [32:0] beat_a(input logic [1:0] s, input logic [95:0] d);
      if (int'(s) >= 3) return {1'b1, 32'hDEAD_BEEF};
      return {1'b0, d[int'(s)*32 +: 32]};
   endfunction

   function automatic logic [95:0] rnd96();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   task automatic apply_reset(input logic iv);
      reset = 1'b1; in_valid_a = iv; in_valid_b = iv;
      out_ready_a = 1'b0; out_ready_b = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
      mq_a.delete(); mq_b.delete(); exp_err_a = '0;
   endtask

   // one clock of instance A; model advanced with the pre-edge occupancy
   task automatic step_a(input logic iv, input logic [1:0] s, input logic [95:0] d,
                         input logic ordy, output logic acc);
      logic        pop;
      logic [32:0] b;
      in_valid_a = iv; sel_a = s; data_in_a = d; out_ready_a = ordy;
      acc = iv && (mq_a.size() < 2);
      pop = ordy && (mq_a.size() > 0);
      b   = beat_a(s, d);
      @(posedge clk); #1;
      if (pop) void'(mq_a.pop_front());
      if (acc) begin
         mq_a.push_back(b);
         if (b[32] && exp_err_a != 16'hFFFF) exp_err_a = exp_err_a + 16'd1;
      end
   endtask

   task automatic step_b(input logic iv, input logic [1:0] s, input logic [31:0] d,
                         input logic ordy);
      logic acc, pop;
      logic [8:0] b;
      in_valid_b = iv; sel_b = s; data_in_b = d; out_ready_b = ordy;
      acc = iv && (mq_b.size() < 2);
      pop = ordy && (mq_b.size() > 0);
      b   = {1'b0, d[int'(s)*8 +: 8]};
      @(posedge clk); #1;
      if (pop) void'(mq_b.pop_front());
      if (acc) mq_b.push_back(b);
   endtask

   task automatic test_reset();
      apply_reset(1'b1);
      n_cmp++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid_a); end
      n_cmp++; if (out_data_a !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", out_data_a); end
      n_cmp++; if (out_sel_err_a !== 1'b0) begin n_err++; $display("FAIL reset_sel_err got %b want 0", out_sel_err_a); end
      n_cmp++; if (err_count_a !== 16'h0) begin n_err++; $display("FAIL reset_err_count got %h want 0", err_count_a); end
      n_cmp++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready_a); end
   endtask

   task automatic test_single();
      logic acc;
      step_a(1'b1, 2'd1, {32'h3, 32'h2, 32'h1}, 1'b1, acc);
      n_cmp++; if (out_valid_a !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", out_valid_a); end
      n_cmp++; if (out_data_a !== 32'h2) begin n_err++; $display("FAIL single_data got %h want 00000002", out_data_a); end
      n_cmp++; if (out_sel_err_a !== 1'b0) begin n_err++; $display("FAIL single_sel_err got %b want 0", out_sel_err_a); end
      step_a(1'b0, 2'd0, '0, 1'b1, acc);
      n_cmp++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", out_valid_a); end
   endtask

   task automatic test_stream();
      logic acc;
      for (int i = 0; i < 8; i++) begin
         step_a(1'b1, 2'(i % 3), rnd96(), 1'b1, acc);
         n_cmp++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL stream_in_ready beat %0d got %b want 1", i, in_ready_a); end
         n_cmp++; if (out_valid_a !== 1'b1 || out_data_a !== mq_a[0][31:0]) begin
            n_err++; $display("FAIL stream_data beat %0d got v=%b %h want v=1 %h", i, out_valid_a, out_data_a, mq_a[0][31:0]);
         end
      end
      step_a(1'b0, 2'd0, '0, 1'b1, acc);
   endtask

   task automatic test_back_pressure();
      logic [95:0] src[3];
      logic [31:0] want[3];
      logic [31:0] got[$];
      logic        acc, iv;
      int          idx = 0;
      for (int i = 0; i < 3; i++) begin
         src[i]  = rnd96();
         want[i] = src[i][i*32 +: 32];
      end
      for (int c = 0; c < 3; c++) begin
         step_a(1'b1, 2'(idx), src[idx], 1'b0, acc);
         if (acc) idx++;
         n_cmp++; if (in_ready_a !== (c == 0)) begin
            n_err++; $display("FAIL bp_in_ready cycle %0d got %b want %b", c, in_ready_a, (c == 0));
         end
      end
      n_cmp++; if (idx != 2) begin n_err++; $display("FAIL bp_accepted got %0d want 2", idx); end
      n_cmp++; if (out_data_a !== want[0]) begin n_err++; $display("FAIL bp_hold got %h want %h", out_data_a, want[0]); end
      for (int c = 0; c < 10; c++) begin
         if (out_valid_a) got.push_back(out_data_a);
         iv = (idx < 3);
         step_a(iv, 2'(idx % 3), src[idx % 3], 1'b1, acc);
         if (acc) idx++;
         n_cmp++; if (out_valid_a !== (mq_a.size() > 0) || (out_valid_a && out_data_a !== mq_a[0][31:0])) begin
            n_err++; $display("FAIL bp_drain cycle %0d got v=%b %h", c, out_valid_a, out_data_a);
         end
      end
      n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL bp_count got %0d want 3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== want[i]) begin n_err++; $display("FAIL bp_order %0d got %h want %h", i, got[i], want[i]); end
      end
   endtask

   task automatic test_illegal();
      logic acc;
      apply_reset(1'b0);
      step_a(1'b1, 2'd3, rnd96(), 1'b0, acc);
      n_cmp++; if (out_data_a !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL illegal_data got %h want deadbeef", out_data_a); end
      n_cmp++; if (out_sel_err_a !== 1'b1) begin n_err++; $display("FAIL illegal_flag got %b want 1", out_sel_err_a); end
      n_cmp++; if (err_count_a !== 16'd1) begin n_err++; $display("FAIL illegal_count got %0d want 1", err_count_a); end
      for (int i = 0; i < 65540; i++) begin
         step_a(1'b1, 2'd3, rnd96(), 1'b1, acc);
         if (err_count_a !== exp_err_a) begin
            n_cmp++; n_err++;
            $display("FAIL sat_track beat %0d got %h want %h", i, err_count_a, exp_err_a);
            break;
         end
      end
      n_cmp++; if (err_count_a !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %h want ffff", err_count_a); end
      step_a(1'b1, 2'd3, rnd96(), 1'b1, acc);
      n_cmp++; if (err_count_a !== 16'hFFFF) begin n_err++; $display("FAIL sat_stay got %h want ffff", err_count_a); end
   endtask

   task automatic test_reset_mid();
      logic acc;
      apply_reset(1'b0);
      step_a(1'b1, 2'd3, rnd96(), 1'b0, acc);
      step_a(1'b1, 2'd0, rnd96(), 1'b0, acc);
      n_cmp++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL mid_full got %b want 0", in_ready_a); end
      apply_reset(1'b1);
      n_cmp++; if (out_valid_a !== 1'b0 || out_data_a !== 32'h0 || err_count_a !== 16'h0 || in_ready_a !== 1'b1) begin
         n_err++; $display("FAIL mid_reset got v=%b d=%h c=%h r=%b want 0/0/0/1", out_valid_a, out_data_a, err_count_a, in_ready_a);
      end
      for (int c = 0; c < 4; c++) begin
         step_a(1'b0, 2'd0, '0, 1'b1, acc);
         n_cmp++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL mid_stale cycle %0d got %b want 0", c, out_valid_a); end
      end
   endtask

   task automatic test_random();
      logic acc;
      apply_reset(1'b0);
      for (int c = 0; c < 3000; c++) begin
         step_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd96(), 1'($urandom_range(0, 1)), acc);
         n_cmp++;
         if (out_valid_a !== (mq_a.size() > 0) || in_ready_a !== (mq_a.size() < 2) ||
             err_count_a !== exp_err_a ||
             (mq_a.size() > 0 && {out_sel_err_a, out_data_a} !== mq_a[0])) begin
            n_err++;
            $display("FAIL rand cycle %0d got v=%b r=%b e=%b d=%h c=%h want n=%0d c=%h", c, out_valid_a,
                     in_ready_a, out_sel_err_a, out_data_a, err_count_a, mq_a.size(), exp_err_a);
         end
      end
   endtask

   task automatic test_sweep();
      apply_reset(1'b0);
      for (int c = 0; c < 400; c++) begin
         step_b(1'($urandom_range(0, 1)), 2'(c < 8 ? c % 4 : $urandom_range(0, 3)), $urandom(), 1'($urandom_range(0, 1)));
         n_cmp++;
         if (out_valid_b !== (mq_b.size() > 0) || in_ready_b !== (mq_b.size() < 2) ||
             out_sel_err_b !== 1'b0 || err_count_b !== 16'h0 ||
             (mq_b.size() > 0 && out_data_b !== mq_b[0][7:0])) begin
            n_err++;
            $display("FAIL sweep cycle %0d got v=%b r=%b e=%b d=%h c=%h", c, out_valid_b, in_ready_b,
                     out_sel_err_b, out_data_b, err_count_b);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid_a = 1'b0; sel_a = '0; data_in_a = '0; out_ready_a = 1'b0;
      in_valid_b = 1'b0; sel_b = '0; data_in_b = '0; out_ready_b = 1'b0;
      exp_err_a = '0;
      #1;
      test_reset();
      test_single();
      test_stream();
      test_back_pressure();
      test_illegal();
      test_reset_mid();
      test_random();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
